// File: rtl/mxv_push_loader.sv
// mxv_push_loader: captures pushed words into an N-vector then an NxN row-major matrix
module mxv_push_loader #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  localparam int IDX_W     = $clog2(N),
  localparam int MIDX_W    = $clog2(N*N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear,
  input  logic [IDX_W-1:0]      vec_rd_idx,
  input  logic [IDX_W-1:0]      mat_rd_row,
  input  logic [IDX_W-1:0]      mat_rd_col,
  output logic [DATA_WIDTH-1:0] vec_rd_data,
  output logic [DATA_WIDTH-1:0] mat_rd_data,
  output logic [1:0]            phase,
  output logic [MIDX_W-1:0]     wr_idx,
  output logic                  loaded,
  output logic                  loaded_pulse
);
  typedef enum logic [1:0] {LOAD_VEC = 2'b00, LOAD_MAT = 2'b01, READY = 2'b10} state_t;
  state_t                  state;
  logic [DATA_WIDTH-1:0]   vec [N];
  logic [DATA_WIDTH-1:0]   mat [N*N];
  logic                    cap;
  logic                    last_vec;
  logic                    last_mat;
  logic [MIDX_W-1:0]       mat_addr;
  assign phase = state;
  // a push counts only outside READY and only when clear is not overriding it
  always_comb begin
    cap      = push && !clear && state != READY;
    last_vec = state == LOAD_VEC && wr_idx == MIDX_W'(N-1);
    last_mat = state == LOAD_MAT && wr_idx == MIDX_W'(N*N-1);
    mat_addr = MIDX_W'(32'(mat_rd_row) * N + 32'(mat_rd_col));
    vec_rd_data = (32'(vec_rd_idx) < N) ? vec[vec_rd_idx] : '0;
    mat_rd_data = (32'(mat_rd_row) < N && 32'(mat_rd_col) < N) ? mat[mat_addr] : '0;
  end
  // load sequencer: the final write of each phase resets the slot pointer and advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LOAD_VEC;
      wr_idx       <= '0;
      loaded       <= 1'b0;
      loaded_pulse <= 1'b0;
    end else begin
      loaded_pulse <= 1'b0;
      if (clear) begin
        state  <= LOAD_VEC;
        wr_idx <= '0;
        loaded <= 1'b0;
      end else if (cap) begin
        wr_idx <= (last_vec || last_mat) ? '0 : wr_idx + MIDX_W'(1);
        if (last_vec) state <= LOAD_MAT;
        if (last_mat) begin
          state        <= READY;
          loaded       <= 1'b1;
          loaded_pulse <= 1'b1;
        end
      end
    end
  end
  // operand storage, written at the slot the sequencer points to
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      for (int i = 0; i < N; i++) vec[i] <= '0;
      for (int i = 0; i < N*N; i++) mat[i] <= '0;
    end else if (cap) begin
      for (int i = 0; i < N; i++)
        if (state == LOAD_VEC && wr_idx == MIDX_W'(i)) vec[i] <= data_in;
      for (int i = 0; i < N*N; i++)
        if (state == LOAD_MAT && wr_idx == MIDX_W'(i)) mat[i] <= data_in;
    end
  end
endmodule

// File: tb/tb_mxv_push_loader.sv
// tb_mxv_push_loader: directed vectors with hand-computed expectations
module tb_mxv_push_loader;
  logic       clk = 0;
  logic       reset = 1;
  logic       push = 0;
  logic [7:0] data_in = 0;
  logic       clear = 0;
  logic [1:0] vec_rd_idx = 0, mat_rd_row = 0, mat_rd_col = 0;
  logic [7:0] vec_rd_data, mat_rd_data;
  logic [1:0] phase;
  logic [3:0] wr_idx;
  logic       loaded, loaded_pulse;
  int         vectors = 0;
  int         miscompares = 0;

  mxv_push_loader dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .clear(clear),
    .vec_rd_idx(vec_rd_idx), .mat_rd_row(mat_rd_row), .mat_rd_col(mat_rd_col),
    .vec_rd_data(vec_rd_data), .mat_rd_data(mat_rd_data), .phase(phase),
    .wr_idx(wr_idx), .loaded(loaded), .loaded_pulse(loaded_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_vec(input int i, input logic [7:0] exp);
    vec_rd_idx = 2'(i);
    #1 check($sformatf("vec[%0d]", i), {24'd0, vec_rd_data}, {24'd0, exp});
  endtask

  task automatic chk_mat(input int k, input logic [7:0] exp);
    mat_rd_row = 2'(k / 4);
    mat_rd_col = 2'(k % 4);
    #1 check($sformatf("mat[%0d][%0d]", k / 4, k % 4), {24'd0, mat_rd_data}, {24'd0, exp});
  endtask

  task automatic chk_state(input string tag, input logic [1:0] ph, input logic [3:0] wi,
                           input logic ld, input logic lp);
    check({tag, ".phase"}, {30'd0, phase}, {30'd0, ph});
    check({tag, ".wr_idx"}, {28'd0, wr_idx}, {28'd0, wi});
    check({tag, ".loaded"}, {31'd0, loaded}, {31'd0, ld});
    check({tag, ".loaded_pulse"}, {31'd0, loaded_pulse}, {31'd0, lp});
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 4; i++) chk_vec(i, 8'h00);
    for (int k = 0; k < 16; k++) chk_mat(k, 8'h00);
  endtask

  task automatic push_word(input logic [7:0] d);
    @(negedge clk);
    push = 1;
    data_in = d;
    @(negedge clk);
    push = 0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  initial begin
    push = 1;
    data_in = 8'h5A;
    repeat (3) @(negedge clk);
    reset = 0;
    push = 0;
    #1 chk_state("reset", 2'd0, 4'd0, 1'b0, 1'b0);
    chk_all_zero("reset");

    push_word(8'h11); @(negedge clk);
    check("vec1.wr_idx", {28'd0, wr_idx}, 32'd1);
    push_word(8'h22); @(negedge clk);
    push_word(8'h33); @(negedge clk);
    push_word(8'h44);
    chk_state("vecdone", 2'd1, 4'd0, 1'b0, 1'b0);
    chk_vec(0, 8'h11); chk_vec(1, 8'h22); chk_vec(2, 8'h33); chk_vec(3, 8'h44);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      push_word(8'(i));
    end
    chk_state("ready", 2'd2, 4'd0, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) chk_mat(k, 8'(k));
    @(negedge clk);
    check("pulse_once", {31'd0, loaded_pulse}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      push_word(8'hFF);
      chk_state("hold", 2'd2, 4'd0, 1'b1, 1'b0);
    end
    chk_vec(0, 8'h11); chk_vec(3, 8'h44);
    for (int k = 0; k < 16; k++) chk_mat(k, 8'(k));

    do_clear();
    chk_state("clr_ready", 2'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) push_word(8'h60 + 8'(i));
    chk_state("mat7", 2'd1, 4'd7, 1'b0, 1'b0);
    @(negedge clk);
    clear = 1;
    push = 1;
    data_in = 8'hAA;
    @(negedge clk);
    clear = 0;
    push = 0;
    chk_state("clr_prio", 2'd0, 4'd0, 1'b0, 1'b0);
    chk_all_zero("clr_prio");

    @(negedge clk);
    push = 1;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'h80 + 8'(i);
      @(negedge clk);
    end
    push = 0;
    chk_state("b2b", 2'd2, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) chk_vec(i, 8'h80 + 8'(i));
    for (int k = 0; k < 16; k++) chk_mat(k, 8'h84 + 8'(k));

    do_clear();
    for (int i = 0; i < 9; i++) push_word(8'h30 + 8'(i));
    chk_state("preabort", 2'd1, 4'd5, 1'b0, 1'b0);
    chk_mat(4, 8'h38);
    @(posedge clk);
    #2 reset = 1;
    #1 chk_state("async_rst", 2'd0, 4'd0, 1'b0, 1'b0);
    chk_vec(0, 8'h00);
    chk_mat(4, 8'h00);
    @(negedge clk);
    reset = 0;
    #1 chk_state("post_rst", 2'd0, 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
